// File: rtl/ifmaps_preload_ctrl.sv
// ifmaps_preload_ctrl
// Sequences a single ifmap job through the ifmaps preload FIFO. Beats from
// the AXIS ifmap DMA are gated into the FIFO while it has room. MAC-side
// read strobes are issued until every requested ifmap vector has been
// consumed. The block then raises a one-cycle done pulse. Stream framing
// (tlast) is checked on every accepted beat.
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_start                  job start pulse, ignored while busy
//   i_input_channel_size     channels per ifmap vector (latched at start)
//   i_pixel_count            ifmap vectors in the job (latched at start)
//   o_busy                   high from the accepted start through the done cycle
//   o_done                   one-cycle completion pulse
//   o_err_tlast              sticky framing error, cleared by the next start
//   i_s_axis_tvalid          AXIS beat valid
//   o_s_axis_tready          AXIS beat ready
//   i_s_axis_tlast           AXIS last beat of job
//   o_load_ifmaps_preload    preload FIFO write strobe
//   i_fifo_full              preload FIFO full
//   i_fifo_empty             preload FIFO empty
//   i_mac_ready              MAC array can consume a vector this cycle
//   o_MAC_read               preload FIFO read strobe (one vector consumed)
module ifmaps_preload_ctrl #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int CH_PER_BEAT          = 6,
    parameter int PIX_CNT_W            = 16,
    parameter int BEAT_CNT_W           = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [11:0]          i_input_channel_size,
    input  logic [PIX_CNT_W-1:0] i_pixel_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err_tlast,
    input  logic                 i_s_axis_tvalid,
    output logic                 o_s_axis_tready,
    input  logic                 i_s_axis_tlast,
    output logic                 o_load_ifmaps_preload,
    input  logic                 i_fifo_full,
    input  logic                 i_fifo_empty,
    input  logic                 i_mac_ready,
    output logic                 o_MAC_read
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [BEAT_CNT_W-1:0] r_beats_per_vec;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [PIX_CNT_W-1:0]  r_wr_vec_cnt;
    logic [PIX_CNT_W-1:0]  r_rd_cnt;
    logic                  r_err_tlast;

    logic [BEAT_CNT_W-1:0] w_beats_per_vec;
    logic                  w_cfg_valid;
    logic                  w_start_ok;
    logic                  w_tready;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_final_beat;
    logic                  w_mac_read;
    logic [PIX_CNT_W-1:0]  w_rd_cnt_next;

    // The preload packer advances its write pointer once offset+CH_PER_BEAT
    // exceeds C, so a vector always occupies floor(C/CH_PER_BEAT)+1 beats,
    // even when C is an exact multiple of CH_PER_BEAT.
    assign w_beats_per_vec = BEAT_CNT_W'(i_input_channel_size / 12'(CH_PER_BEAT))
                           + BEAT_CNT_W'(1);

    assign w_cfg_valid  = (i_input_channel_size != 12'd0) && (i_pixel_count != '0);
    assign w_start_ok   = (r_state == ST_IDLE) && i_start;

    assign w_tready     = (r_state == ST_LOAD) && !i_fifo_full;
    assign w_accept     = w_tready && i_s_axis_tvalid;
    assign w_last_beat  = (r_beat_cnt == r_beats_per_vec - BEAT_CNT_W'(1));
    assign w_final_beat = w_last_beat && (r_wr_vec_cnt == r_pix_cnt - PIX_CNT_W'(1));

    // Reads run alongside writes; the FIFO empty flag is trusted to keep
    // the MAC from reading a vector that has not been fully written.
    assign w_mac_read    = ((r_state == ST_LOAD) || (r_state == ST_DRAIN))
                         && i_mac_ready && !i_fifo_empty && (r_rd_cnt < r_pix_cnt);
    assign w_rd_cnt_next = r_rd_cnt + {{(PIX_CNT_W-1){1'b0}}, w_mac_read};

    assign o_s_axis_tready       = w_tready;
    assign o_load_ifmaps_preload = w_accept;
    assign o_MAC_read            = w_mac_read;
    assign o_err_tlast           = r_err_tlast;

    // Next-state and status outputs. Leaving LOAD always passes through
    // DRAIN, even when the last read has already happened. DRAIN then
    // exits as soon as the read count reaches P, including the cycle in
    // which the final read fires.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = w_cfg_valid ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_final_beat) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_rd_cnt_next == r_pix_cnt) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, latched job configuration and progress counters. An accepted
    // start reloads the configuration and clears every counter and the
    // sticky framing flag. A start that arrives while busy is never
    // accepted, so the latched configuration stays fixed for the whole job.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_beats_per_vec <= '0;
            r_pix_cnt       <= '0;
            r_beat_cnt      <= '0;
            r_wr_vec_cnt    <= '0;
            r_rd_cnt        <= '0;
            r_err_tlast     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_beats_per_vec <= w_beats_per_vec;
                r_pix_cnt       <= i_pixel_count;
                r_beat_cnt      <= '0;
                r_wr_vec_cnt    <= '0;
                r_rd_cnt        <= '0;
                r_err_tlast     <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_last_beat) begin
                        r_beat_cnt   <= '0;
                        r_wr_vec_cnt <= r_wr_vec_cnt + PIX_CNT_W'(1);
                    end else begin
                        r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                    end
                    // tlast must be present exactly on the final beat of the job.
                    // A mismatch is recorded, but the job keeps counting.
                    if (i_s_axis_tlast != w_final_beat) begin
                        r_err_tlast <= 1'b1;
                    end
                end
                if (w_mac_read) begin
                    r_rd_cnt <= w_rd_cnt_next;
                end
            end
        end
    end

endmodule
